sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single-ported byte SRAM: port A (host reads) has
// fixed priority, and port B (loader) is forced through after STARVE_LIMIT losses.
module sram_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic [15:0] a_addr,
    output logic [7:0]  a_rdata,
    output logic        a_ack,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [15:0] b_addr,
    input  logic [7:0]  b_wdata,
    output logic [7:0]  b_rdata,
    output logic        b_ack,
    output logic [15:0] address,
    output logic [7:0]  datain,
    input  logic [7:0]  dataout,
    output logic        CS,
    output logic        WE
);

    localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_starve;
    logic           r_grant_b;
    logic [15:0]    r_address;
    logic [7:0]     r_datain;
    logic           r_cs;
    logic           r_we;
    logic           r_a_ack;
    logic           r_b_ack;
    logic [7:0]     r_a_rdata;
    logic [7:0]     r_b_rdata;
    logic           w_b_wins;

    // B wins only when A is absent or B has lost STARVE_LIMIT times in a row.
    assign w_b_wins = b_req && (!a_req || (r_starve == LIMIT));

    // NOTE: all state is updated with non-blocking assignments so every register
    // sees the pre-edge values of its neighbours, exactly like the hardware.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_starve  <= '0;
            r_grant_b <= 1'b0;
            r_address <= '0;
            r_datain  <= '0;
            r_cs      <= 1'b0;
            r_we      <= 1'b0;
            r_a_ack   <= 1'b0;
            r_b_ack   <= 1'b0;
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_a_ack <= 1'b0;
                    r_b_ack <= 1'b0;
                    if (a_req || b_req) begin
                        r_state   <= ACCESS;
                        r_grant_b <= w_b_wins;
                        r_cs      <= 1'b1;
                        if (w_b_wins) begin
                            r_address <= b_addr;
                            r_we      <= b_we;
                            r_starve  <= '0;
                            if (b_we) begin
                                r_datain <= b_wdata;
                            end
                        end else begin
                            r_address <= a_addr;
                            r_we      <= 1'b0;
                            if (b_req && (r_starve != LIMIT)) begin
                                r_starve <= r_starve + 1'b1;
                            end
                        end
                    end
                end
                ACCESS: begin
                    r_state <= DONE;
                    r_cs    <= 1'b0;
                    r_we    <= 1'b0;
                    // Writes leave the winner's read-data register untouched.
                    if (!r_we) begin
                        if (r_grant_b) begin
                            r_b_rdata <= dataout;
                        end else begin
                            r_a_rdata <= dataout;
                        end
                    end
                    r_a_ack <= !r_grant_b;
                    r_b_ack <= r_grant_b;
                end
                DONE: begin
                    r_state <= IDLE;
                    r_a_ack <= 1'b0;
                    r_b_ack <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_cs    <= 1'b0;
                    r_we    <= 1'b0;
                    r_a_ack <= 1'b0;
                    r_b_ack <= 1'b0;
                end
            endcase
        end
    end

    assign address = r_address;
    assign datain  = r_datain;
    assign CS      = r_cs;
    assign WE      = r_we;
    assign a_ack   = r_a_ack;
    assign b_ack   = r_b_ack;
    assign a_rdata = r_a_rdata;
    assign b_rdata = r_b_rdata;

endmodule
